// File: rtl/regfile_self_check_pkg.sv
// Shared definitions for the on-FPGA processor result checkers.
// Holds the run-state encoding and index-width helper.
package regfile_self_check_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE
    } check_state_t;

    // Index width for a table of n entries, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) w++;
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/regfile_self_check_if.sv
// Expected-table lookup and spare regfile read port seen by the checker.
// The checker is the master: it drives the index and the read address.
interface regfile_self_check_if
    import regfile_self_check_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_AW     = 5,
    parameter int NUM_CHECKS = 8
);
    localparam int IDX_W = clog2_min1(NUM_CHECKS);

    logic [IDX_W-1:0]  tbl_index;
    logic [REG_AW-1:0] tbl_reg;
    logic [DATA_W-1:0] tbl_value;
    logic [REG_AW-1:0] rf_read_addr;
    logic [DATA_W-1:0] rf_read_data;

    modport master (
        output tbl_index, rf_read_addr,
        input  tbl_reg, tbl_value, rf_read_data
    );

    modport slave (
        input  tbl_index, rf_read_addr,
        output tbl_reg, tbl_value, rf_read_data
    );
endinterface

// File: rtl/regfile_self_check_delay_line.sv
// Valid+data shift register that lines expected entries up with regfile read data.
// Depth 0 is a plain wire; flush drops every in-flight entry.
module check_delay_line #(
    parameter int DATA_W = 37,
    parameter int STAGES = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              vld_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              vld_out,
    output logic [DATA_W-1:0] data_out
);
    generate
        if (STAGES == 0) begin : g_wire
            logic unused_ctrl;
            assign unused_ctrl = ^{clock, reset, flush};
            assign vld_out     = vld_in;
            assign data_out    = data_in;
        end else begin : g_pipe
            logic              vld_p  [STAGES];
            logic [DATA_W-1:0] data_p [STAGES];

            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    for (int i = 0; i < STAGES; i++) vld_p[i] <= 1'b0;
                end else if (flush) begin
                    for (int i = 0; i < STAGES; i++) vld_p[i] <= 1'b0;
                end else begin
                    vld_p[0] <= vld_in;
                    for (int i = 1; i < STAGES; i++) vld_p[i] <= vld_p[i-1];
                end
            end

            // Payload needs no reset: it is only looked at when its valid is set.
            always_ff @(posedge clock) begin
                data_p[0] <= data_in;
                for (int i = 1; i < STAGES; i++) data_p[i] <= data_p[i-1];
            end

            assign vld_out  = vld_p[STAGES-1];
            assign data_out = data_p[STAGES-1];
        end
    endgenerate
endmodule

// File: rtl/regfile_self_check.sv
// Register-file result checker: waits, reads each table register through a spare
// read port, compares against the expected table and records errors / first mismatch.
module regfile_self_check
    import regfile_self_check_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int REG_AW       = 5,
    parameter int NUM_CHECKS   = 8,
    parameter int READ_LATENCY = 1,
    parameter int CNT_W        = 16,
    parameter int ERR_W        = 8,
    parameter int STOP_ON_FAIL = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [CNT_W-1:0]      cycle_limit,
    regfile_self_check_if.master  bus,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ERR_W-1:0]      error_count,
    output logic                  first_fail_valid,
    output logic [REG_AW-1:0]     first_fail_reg,
    output logic [DATA_W-1:0]     first_fail_expected,
    output logic [DATA_W-1:0]     first_fail_actual
);
    localparam int                IDX_W    = clog2_min1(NUM_CHECKS);
    localparam int                ENT_W    = REG_AW + DATA_W;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_CHECKS - 1);

    check_state_t      state;
    logic [CNT_W-1:0]  wcnt;
    logic [IDX_W-1:0]  idx;
    logic [1:0]        dcnt;

    logic              issuing, kill_issue, mismatch, stop_now;
    logic              vld_p0, vld_cmp;
    logic [ENT_W-1:0]  ent_p0, ent_cmp;
    logic [REG_AW-1:0] cmp_reg;
    logic [DATA_W-1:0] cmp_exp;

    function automatic logic [ERR_W-1:0] err_sat_inc(input logic [ERR_W-1:0] v);
        return (&v) ? v : v + ERR_W'(1);
    endfunction

    // A stop found in the issue cycle also withholds that cycle's read.
    generate
        if (READ_LATENCY > 0 && STOP_ON_FAIL != 0) begin : g_kill
            assign kill_issue = mismatch;
        end else begin : g_nokill
            assign kill_issue = 1'b0;
        end
    endgenerate

    assign issuing          = (state == ST_ISSUE) && !kill_issue;
    assign bus.tbl_index    = issuing ? idx : '0;
    assign bus.rf_read_addr = issuing ? bus.tbl_reg : '0;
    assign vld_p0           = issuing;
    assign ent_p0           = {bus.tbl_reg, bus.tbl_value};

    check_delay_line #(
        .DATA_W (ENT_W),
        .STAGES (READ_LATENCY)
    ) u_delay (
        .clock    (clock),
        .reset    (reset),
        .flush    (stop_now),
        .vld_in   (vld_p0),
        .data_in  (ent_p0),
        .vld_out  (vld_cmp),
        .data_out (ent_cmp)
    );

    // Compare stage: the entry emerging now pairs with the read data arriving now.
    assign {cmp_reg, cmp_exp} = ent_cmp;
    assign mismatch = vld_cmp && (bus.rf_read_data !== cmp_exp);
    assign stop_now = (STOP_ON_FAIL != 0) && mismatch;

    assign busy = (state == ST_WAIT) || (state == ST_ISSUE) || (state == ST_DRAIN);
    assign done = (state == ST_DONE);
    assign pass = done && (error_count == '0);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state               <= ST_IDLE;
            wcnt                <= '0;
            idx                 <= '0;
            dcnt                <= '0;
            error_count         <= '0;
            first_fail_valid    <= 1'b0;
            first_fail_reg      <= '0;
            first_fail_expected <= '0;
            first_fail_actual   <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        error_count         <= '0;
                        first_fail_valid    <= 1'b0;
                        first_fail_reg      <= '0;
                        first_fail_expected <= '0;
                        first_fail_actual   <= '0;
                        idx                 <= '0;
                        if (cycle_limit == '0) begin
                            state <= ST_ISSUE;
                        end else begin
                            wcnt  <= cycle_limit - CNT_W'(1);
                            state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (wcnt == '0) state <= ST_ISSUE;
                    else            wcnt  <= wcnt - CNT_W'(1);
                end
                ST_ISSUE: begin
                    if (stop_now) begin
                        idx   <= '0;
                        state <= ST_DONE;
                    end else if (idx == LAST_IDX) begin
                        idx <= '0;
                        if (READ_LATENCY == 0) begin
                            state <= ST_DONE;
                        end else begin
                            dcnt  <= 2'(READ_LATENCY - 1);
                            state <= ST_DRAIN;
                        end
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                ST_DRAIN: begin
                    if (stop_now || dcnt == 2'd0) state <= ST_DONE;
                    else                          dcnt  <= dcnt - 2'd1;
                end
                default: state <= ST_IDLE;
            endcase

            if (mismatch) begin
                error_count <= err_sat_inc(error_count);
                if (!first_fail_valid) begin
                    first_fail_valid    <= 1'b1;
                    first_fail_reg      <= cmp_reg;
                    first_fail_expected <= cmp_exp;
                    first_fail_actual   <= bus.rf_read_data;
                end
            end
        end
    end
endmodule

// File: tb/tb_regfile_self_check.sv
// Directed bench for regfile_self_check: four instances cover the default,
// saturating, stop-on-fail and zero-latency configurations.
module tb_regfile_self_check;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] cyc_lim = '0;
    logic        start0 = 1'b0, start1 = 1'b0, start2 = 1'b0, start3 = 1'b0;
    int          n_tests = 0;
    int          n_fail = 0;
    int          max_idx;
    int          n;

    logic        busy0, done0, pass0, ffv0;
    logic        busy1, done1, pass1, ffv1;
    logic        busy2, done2, pass2, ffv2;
    logic        busy3, done3, pass3, ffv3;
    logic [7:0]  err0, err2, err3;
    logic [1:0]  err1;
    logic [4:0]  ffr0, ffr1, ffr2, ffr3;
    logic [31:0] ffe0, ffe1, ffe2, ffe3;
    logic [31:0] ffa0, ffa1, ffa2, ffa3;

    logic [31:0] rf0 [32];
    logic [31:0] rf1 [32];
    logic [31:0] rf2 [32];
    logic [31:0] rf3 [32];
    logic [31:0] rd2_p;

    always #5 clk = ~clk;

    regfile_self_check_if #(.DATA_W(32), .REG_AW(5), .NUM_CHECKS(8)) bus0 ();
    regfile_self_check_if #(.DATA_W(32), .REG_AW(5), .NUM_CHECKS(8)) bus1 ();
    regfile_self_check_if #(.DATA_W(32), .REG_AW(5), .NUM_CHECKS(8)) bus2 ();
    regfile_self_check_if #(.DATA_W(32), .REG_AW(5), .NUM_CHECKS(8)) bus3 ();

    function automatic logic [4:0] tbl_reg_f(input logic [2:0] i);
        case (i)
            3'd0: return 5'd2;
            3'd1: return 5'd3;
            3'd2: return 5'd4;
            3'd3: return 5'd5;
            3'd4: return 5'd6;
            3'd5: return 5'd7;
            3'd6: return 5'd8;
            default: return 5'd11;
        endcase
    endfunction

    function automatic logic [31:0] tbl_val_f(input logic [2:0] i);
        case (i)
            3'd0: return 32'd2;
            3'd1: return 32'd5;
            3'd2: return 32'd2;
            3'd3: return 32'd2;
            3'd4: return 32'd3;
            3'd5: return 32'd12;
            3'd6: return 32'd6;
            default: return 32'd12;
        endcase
    endfunction

    assign bus0.tbl_reg   = tbl_reg_f(bus0.tbl_index);
    assign bus0.tbl_value = tbl_val_f(bus0.tbl_index);
    assign bus1.tbl_reg   = tbl_reg_f(bus1.tbl_index);
    assign bus1.tbl_value = tbl_val_f(bus1.tbl_index);
    assign bus2.tbl_reg   = tbl_reg_f(bus2.tbl_index);
    assign bus2.tbl_value = tbl_val_f(bus2.tbl_index);
    assign bus3.tbl_reg   = tbl_reg_f(bus3.tbl_index);
    assign bus3.tbl_value = tbl_val_f(bus3.tbl_index);

    // Regfile models with read latency 1, 1, 2 and 0.
    always_ff @(posedge clk) bus0.rf_read_data <= rf0[bus0.rf_read_addr];
    always_ff @(posedge clk) bus1.rf_read_data <= rf1[bus1.rf_read_addr];
    always_ff @(posedge clk) begin
        rd2_p              <= rf2[bus2.rf_read_addr];
        bus2.rf_read_data  <= rd2_p;
    end
    assign bus3.rf_read_data = rf3[bus3.rf_read_addr];

    regfile_self_check #(.READ_LATENCY(1), .ERR_W(8), .STOP_ON_FAIL(0)) u0 (
        .clock(clk), .reset(rst_n), .start(start0), .cycle_limit(cyc_lim), .bus(bus0),
        .busy(busy0), .done(done0), .pass(pass0), .error_count(err0),
        .first_fail_valid(ffv0), .first_fail_reg(ffr0),
        .first_fail_expected(ffe0), .first_fail_actual(ffa0));

    regfile_self_check #(.READ_LATENCY(1), .ERR_W(2), .STOP_ON_FAIL(0)) u1 (
        .clock(clk), .reset(rst_n), .start(start1), .cycle_limit(cyc_lim), .bus(bus1),
        .busy(busy1), .done(done1), .pass(pass1), .error_count(err1),
        .first_fail_valid(ffv1), .first_fail_reg(ffr1),
        .first_fail_expected(ffe1), .first_fail_actual(ffa1));

    regfile_self_check #(.READ_LATENCY(2), .ERR_W(8), .STOP_ON_FAIL(1)) u2 (
        .clock(clk), .reset(rst_n), .start(start2), .cycle_limit(cyc_lim), .bus(bus2),
        .busy(busy2), .done(done2), .pass(pass2), .error_count(err2),
        .first_fail_valid(ffv2), .first_fail_reg(ffr2),
        .first_fail_expected(ffe2), .first_fail_actual(ffa2));

    regfile_self_check #(.READ_LATENCY(0), .ERR_W(8), .STOP_ON_FAIL(0)) u3 (
        .clock(clk), .reset(rst_n), .start(start3), .cycle_limit(cyc_lim), .bus(bus3),
        .busy(busy3), .done(done3), .pass(pass3), .error_count(err3),
        .first_fail_valid(ffv3), .first_fail_reg(ffr3),
        .first_fail_expected(ffe3), .first_fail_actual(ffa3));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_start(input int u, input logic v);
        case (u)
            0: start0 = v;
            1: start1 = v;
            2: start2 = v;
            default: start3 = v;
        endcase
    endtask

    function automatic logic get_done(input int u);
        case (u)
            0: return done0;
            1: return done1;
            2: return done2;
            default: return done3;
        endcase
    endfunction

    function automatic logic get_busy(input int u);
        case (u)
            0: return busy0;
            1: return busy1;
            2: return busy2;
            default: return busy3;
        endcase
    endfunction

    function automatic int get_idx(input int u);
        case (u)
            0: return int'(bus0.tbl_index);
            1: return int'(bus1.tbl_index);
            2: return int'(bus2.tbl_index);
            default: return int'(bus3.tbl_index);
        endcase
    endfunction

    // Pulse start, then count cycles until done; optionally re-pulse start at cycle 'poke'.
    task automatic go(input int u, input logic [15:0] lim, input int poke, output int cycles);
        cyc_lim = lim;
        set_start(u, 1'b1);
        tick();
        set_start(u, 1'b0);
        cycles  = 1;
        max_idx = 0;
        if (get_busy(u) && get_idx(u) > max_idx) max_idx = get_idx(u);
        while (!get_done(u) && cycles < 100) begin
            set_start(u, cycles == poke);
            tick();
            cycles++;
            if (get_busy(u) && get_idx(u) > max_idx) max_idx = get_idx(u);
        end
        set_start(u, 1'b0);
    endtask

    initial begin
        for (int r = 0; r < 32; r++) begin
            rf0[r] = 32'hDEAD_0000 | r;
            rf1[r] = 32'hDEAD_0000 | r;
            rf2[r] = 32'hDEAD_0000 | r;
            rf3[r] = 32'hDEAD_0000 | r;
        end
        for (int i = 0; i < 8; i++) begin
            rf0[tbl_reg_f(3'(i))] = tbl_val_f(3'(i));
            rf1[tbl_reg_f(3'(i))] = tbl_val_f(3'(i)) + 32'd1;
            rf2[tbl_reg_f(3'(i))] = tbl_val_f(3'(i));
            rf3[tbl_reg_f(3'(i))] = tbl_val_f(3'(i));
        end
        rf2[3] = 32'd99;

        tick();
        tick();
        chk("rst_done",  done0, 1'b0);
        chk("rst_busy",  busy0, 1'b0);
        chk("rst_err",   err0, 8'd0);
        chk("rst_index", bus0.tbl_index, 3'd0);
        rst_n = 1'b1;
        tick();

        // All registers match, 9-cycle wait, latency 1.
        go(0, 16'd9, -1, n);
        chk("t1_latency", n, 19);
        chk("t1_pass", pass0, 1'b1);
        chk("t1_err",  err0, 8'd0);
        chk("t1_ffv",  ffv0, 1'b0);
        chk("t1_maxidx", max_idx, 7);

        // r7 wrong: one error, first-fail capture.
        rf0[7] = 32'd13;
        go(0, 16'd9, -1, n);
        chk("t2_latency", n, 19);
        chk("t2_err",  err0, 8'd1);
        chk("t2_ffv",  ffv0, 1'b1);
        chk("t2_ffreg", ffr0, 5'd7);
        chk("t2_ffexp", ffe0, 32'hC);
        chk("t2_ffact", ffa0, 32'hD);
        chk("t2_pass", pass0, 1'b0);

        // Every entry wrong with a 2-bit error counter.
        go(1, 16'd2, -1, n);
        chk("t3_latency", n, 12);
        chk("t3_err_sat", err1, 2'd3);
        chk("t3_ffreg", ffr1, 5'd2);
        chk("t3_ffexp", ffe1, 32'd2);
        chk("t3_ffact", ffa1, 32'd3);
        chk("t3_pass", pass1, 1'b0);

        // Stop on first fail, latency 2, mismatch at index 1 (r3).
        go(2, 16'd0, -1, n);
        chk("t4_latency", n, 5);
        chk("t4_maxidx", max_idx, 2);
        chk("t4_err", err2, 8'd1);
        chk("t4_ffreg", ffr2, 5'd3);
        chk("t4_ffact", ffa2, 32'd99);
        chk("t4_pass", pass2, 1'b0);

        // Zero wait, zero latency, extra start while busy.
        go(3, 16'd0, 4, n);
        chk("t5_latency", n, 9);
        chk("t5_pass", pass3, 1'b1);
        chk("t5_err", err3, 8'd0);

        // Asynchronous reset in the middle of ISSUE.
        cyc_lim = 16'd0;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        repeat (7) tick();
        chk("t6_pre_err", err0, 8'd1);
        chk("t6_pre_busy", busy0, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_busy",  busy0, 1'b0);
        chk("t6_done",  done0, 1'b0);
        chk("t6_err",   err0, 8'd0);
        chk("t6_ffv",   ffv0, 1'b0);
        chk("t6_ffreg", ffr0, 5'd0);
        chk("t6_index", bus0.tbl_index, 3'd0);
        chk("t6_addr",  bus0.rf_read_addr, 5'd0);
        tick();
        rst_n = 1'b1;
        rf0[7] = 32'd12;
        tick();
        go(0, 16'd3, -1, n);
        chk("t6_latency", n, 13);
        chk("t6_pass", pass0, 1'b1);
        chk("t6_err_after", err0, 8'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
